// File: rtl/ddr_rr_arbiter_pkg.sv
// Shared definitions for the DDR port arbiter: FSM encodings and grant index sizing.
package ddr_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    // A single-port build would give $clog2 = 0, so the index never drops below one bit.
    function automatic int grant_width(input int nports);
        return (nports > 1) ? $clog2(nports) : 1;
    endfunction

endpackage

// File: rtl/ddr_rr_arbiter_rr_pick.sv
// Combinational winner selection: rotating search after 'last', or lowest index first.
module rr_pick #(
    parameter int NPORTS = 2,
    parameter int GW     = 1
) (
    input  logic [NPORTS-1:0] req,
    input  logic [GW-1:0]     last,
    input  logic              rr,
    output logic [GW-1:0]     winner,
    output logic              any_req
);

    logic found;

    always_comb begin
        winner  = '0;
        found   = 1'b0;
        any_req = |req;
        if (rr) begin
            // Offsets 1..NPORTS visit every port once, ending on 'last' itself.
            for (int k = 1; k <= NPORTS; k++) begin
                logic [GW-1:0] idx;
                idx = GW'((int'(last) + k) % NPORTS);
                if (!found && req[idx]) begin
                    winner = idx;
                    found  = 1'b1;
                end
            end
        end else begin
            for (int i = NPORTS - 1; i >= 0; i--) begin
                if (req[GW'(i)]) begin
                    winner = GW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/ddr_rr_arbiter.sv
// N-port valid/ready arbiter in front of the single 32-bit DDR controller port.
module ddr_rr_arbiter
    import ddr_rr_arbiter_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int AW     = 24,
    parameter int RR     = 1
) (
    input  logic                 clkrv,
    input  logic                 rst,
    input  logic [NPORTS*AW-1:0] m_addr,
    input  logic [NPORTS*32-1:0] m_wdata,
    input  logic [NPORTS*4-1:0]  m_wstrb,
    input  logic [NPORTS-1:0]    m_valid,
    output logic [NPORTS-1:0]    m_ready,
    output logic [31:0]          m_rdata,
    output logic [AW-1:0]        ddr_addr,
    output logic [31:0]          ddr_wdata,
    output logic [3:0]           ddr_wstrb,
    output logic                 ddr_valid,
    input  logic                 ddr_ready,
    input  logic [31:0]          ddr_rdata
);

    localparam int GW = grant_width(NPORTS);
    localparam logic [NPORTS-1:0] ONE_HOT0 = {{(NPORTS-1){1'b0}}, 1'b1};

    logic [AW-1:0] addr_arr  [NPORTS];
    logic [31:0]   wdata_arr [NPORTS];
    logic [3:0]    wstrb_arr [NPORTS];

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_unpack
            assign addr_arr[gi]  = m_addr[gi*AW +: AW];
            assign wdata_arr[gi] = m_wdata[gi*32 +: 32];
            assign wstrb_arr[gi] = m_wstrb[gi*4 +: 4];
        end
    endgenerate

    arb_state_t        state_reg, state_next;
    logic [GW-1:0]     grant_reg, grant_next;
    logic [GW-1:0]     last_reg, last_next;
    logic [AW-1:0]     ddr_addr_reg, ddr_addr_next;
    logic [31:0]       ddr_wdata_reg, ddr_wdata_next;
    logic [3:0]        ddr_wstrb_reg, ddr_wstrb_next;
    logic              ddr_valid_reg, ddr_valid_next;
    logic [NPORTS-1:0] m_ready_reg, m_ready_next;
    logic [31:0]       m_rdata_reg, m_rdata_next;

    logic [GW-1:0]     winner;
    logic              any_req;

    rr_pick #(
        .NPORTS (NPORTS),
        .GW     (GW)
    ) u_pick (
        .req     (m_valid),
        .last    (last_reg),
        .rr      (RR != 0),
        .winner  (winner),
        .any_req (any_req)
    );

    always_ff @(posedge clkrv) begin
        if (rst) begin
            state_reg     <= ARB_IDLE;
            grant_reg     <= '0;
            last_reg      <= GW'(NPORTS - 1);
            ddr_addr_reg  <= '0;
            ddr_wdata_reg <= '0;
            ddr_wstrb_reg <= '0;
            ddr_valid_reg <= 1'b0;
            m_ready_reg   <= '0;
            m_rdata_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            last_reg      <= last_next;
            ddr_addr_reg  <= ddr_addr_next;
            ddr_wdata_reg <= ddr_wdata_next;
            ddr_wstrb_reg <= ddr_wstrb_next;
            ddr_valid_reg <= ddr_valid_next;
            m_ready_reg   <= m_ready_next;
            m_rdata_reg   <= m_rdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        last_next      = last_reg;
        ddr_addr_next  = ddr_addr_reg;
        ddr_wdata_next = ddr_wdata_reg;
        ddr_wstrb_next = ddr_wstrb_reg;
        ddr_valid_next = ddr_valid_reg;
        m_ready_next   = m_ready_reg;
        m_rdata_next   = m_rdata_reg;
        case (state_reg)
            ARB_IDLE: begin
                // A ready still high here belongs to the previous access.
                if (!ddr_ready && any_req) begin
                    ddr_addr_next  = addr_arr[winner];
                    ddr_wdata_next = wdata_arr[winner];
                    ddr_wstrb_next = wstrb_arr[winner];
                    ddr_valid_next = 1'b1;
                    grant_next     = winner;
                    last_next      = winner;
                    state_next     = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (ddr_ready) begin
                    ddr_valid_next = 1'b0;
                    m_rdata_next   = ddr_rdata;
                    m_ready_next   = ONE_HOT0 << grant_reg;
                    state_next     = ARB_DONE;
                end
            end
            ARB_DONE: begin
                m_ready_next = '0;
                state_next   = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    assign ddr_addr  = ddr_addr_reg;
    assign ddr_wdata = ddr_wdata_reg;
    assign ddr_wstrb = ddr_wstrb_reg;
    assign ddr_valid = ddr_valid_reg;
    assign m_ready   = m_ready_reg;
    assign m_rdata   = m_rdata_reg;

endmodule

// File: tb/tb_ddr_rr_arbiter.sv
// Directed bench: two-port RR instance for protocol cases, two three-port instances for grant order.
module tb_ddr_rr_arbiter;

    logic clkrv = 1'b0;
    logic rst   = 1'b1;
    always #5 clkrv = ~clkrv;

    int checks = 0;
    int errors = 0;

    // Two-port, round-robin
    logic [47:0] m_addr2  = '0;
    logic [63:0] m_wdata2 = '0;
    logic [7:0]  m_wstrb2 = '0;
    logic [1:0]  m_valid2 = '0;
    logic [1:0]  m_ready2;
    logic [31:0] m_rdata2;
    logic [23:0] ddr_addr2;
    logic [31:0] ddr_wdata2;
    logic [3:0]  ddr_wstrb2;
    logic        ddr_valid2;
    logic        ddr_ready2 = 1'b0;
    logic [31:0] ddr_rdata2 = '0;

    // Three-port, shared stimulus, RR and fixed priority
    logic [71:0] m_addr3  = '0;
    logic [95:0] m_wdata3 = '0;
    logic [11:0] m_wstrb3 = '0;
    logic [2:0]  m_valid3 = '0;
    logic [2:0]  m_ready3a, m_ready3f;
    logic [31:0] m_rdata3a, m_rdata3f;
    logic [23:0] ddr_addr3a, ddr_addr3f;
    logic [31:0] ddr_wdata3a, ddr_wdata3f;
    logic [3:0]  ddr_wstrb3a, ddr_wstrb3f;
    logic        ddr_valid3a, ddr_valid3f;
    logic        ddr_ready3 = 1'b0;
    logic [31:0] ddr_rdata3 = '0;

    ddr_rr_arbiter #(.NPORTS(2), .AW(24), .RR(1)) dut2 (
        .clkrv(clkrv), .rst(rst),
        .m_addr(m_addr2), .m_wdata(m_wdata2), .m_wstrb(m_wstrb2), .m_valid(m_valid2),
        .m_ready(m_ready2), .m_rdata(m_rdata2),
        .ddr_addr(ddr_addr2), .ddr_wdata(ddr_wdata2), .ddr_wstrb(ddr_wstrb2),
        .ddr_valid(ddr_valid2), .ddr_ready(ddr_ready2), .ddr_rdata(ddr_rdata2)
    );

    ddr_rr_arbiter #(.NPORTS(3), .AW(24), .RR(1)) dut3a (
        .clkrv(clkrv), .rst(rst),
        .m_addr(m_addr3), .m_wdata(m_wdata3), .m_wstrb(m_wstrb3), .m_valid(m_valid3),
        .m_ready(m_ready3a), .m_rdata(m_rdata3a),
        .ddr_addr(ddr_addr3a), .ddr_wdata(ddr_wdata3a), .ddr_wstrb(ddr_wstrb3a),
        .ddr_valid(ddr_valid3a), .ddr_ready(ddr_ready3), .ddr_rdata(ddr_rdata3)
    );

    ddr_rr_arbiter #(.NPORTS(3), .AW(24), .RR(0)) dut3f (
        .clkrv(clkrv), .rst(rst),
        .m_addr(m_addr3), .m_wdata(m_wdata3), .m_wstrb(m_wstrb3), .m_valid(m_valid3),
        .m_ready(m_ready3f), .m_rdata(m_rdata3f),
        .ddr_addr(ddr_addr3f), .ddr_wdata(ddr_wdata3f), .ddr_wstrb(ddr_wstrb3f),
        .ddr_valid(ddr_valid3f), .ddr_ready(ddr_ready3), .ddr_rdata(ddr_rdata3)
    );

    task automatic tick();
        @(posedge clkrv);
        @(negedge clkrv);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic ok;
        logic [2:0] exp_rdy;

        // Reset held two edges with both ports requesting
        m_addr2  = {24'h800010, 24'h000100};
        m_valid2 = 2'b11;
        tick();
        tick();
        check("rst_valid", ddr_valid2, 0);
        check("rst_ready", m_ready2, 0);
        check("rst_rdata", m_rdata2, 0);
        check("rst_addr", ddr_addr2, 0);
        check("rst_wdata", ddr_wdata2, 0);
        check("rst_wstrb", ddr_wstrb2, 0);
        rst = 1'b0;
        check("post_rst_no_valid", ddr_valid2, 0);
        tick();
        check("first_grant_valid", ddr_valid2, 1);
        check("first_grant_addr", ddr_addr2, 32'h000100);
        ddr_ready2 = 1'b1;
        ddr_rdata2 = 32'h11111111;
        tick();
        check("first_mready", m_ready2, 2'b01);
        check("first_rdata", m_rdata2, 32'h11111111);
        ddr_ready2 = 1'b0;
        m_valid2   = 2'b10;
        tick();
        check("done_clear", m_ready2, 0);
        check("done_novalid", ddr_valid2, 0);

        // Single read from port 1, controller answers three cycles later
        tick();
        check("rd_valid", ddr_valid2, 1);
        check("rd_addr", ddr_addr2, 32'h800010);
        check("rd_wstrb", ddr_wstrb2, 0);
        tick();
        tick();
        check("rd_hold_valid", ddr_valid2, 1);
        check("rd_no_early_ready", m_ready2, 0);
        ddr_ready2 = 1'b1;
        ddr_rdata2 = 32'hDEADBEEF;
        tick();
        check("rd_mready", m_ready2, 2'b10);
        check("rd_rdata", m_rdata2, 32'hDEADBEEF);
        check("rd_valid_drop", ddr_valid2, 0);
        ddr_ready2 = 1'b0;
        m_valid2   = 2'b00;
        tick();
        check("rd_pulse_one_cycle", m_ready2, 0);

        // Byte write from port 1, payload changed mid-WAIT
        m_addr2  = {24'h000040, 24'h000100};
        m_wdata2 = {32'h00AB0000, 32'h0};
        m_wstrb2 = {4'b0100, 4'b0000};
        m_valid2 = 2'b10;
        tick();
        check("wr_valid", ddr_valid2, 1);
        check("wr_addr", ddr_addr2, 32'h000040);
        check("wr_wdata", ddr_wdata2, 32'h00AB0000);
        check("wr_wstrb", ddr_wstrb2, 4'b0100);
        m_wdata2 = {32'h12345678, 32'h0};
        m_wstrb2 = {4'b1111, 4'b0000};
        tick();
        check("wr_hold_wdata", ddr_wdata2, 32'h00AB0000);
        check("wr_hold_wstrb", ddr_wstrb2, 4'b0100);
        ddr_ready2 = 1'b1;
        ddr_rdata2 = 32'hCAFEF00D;
        tick();
        check("wr_mready", m_ready2, 2'b10);
        check("wr_rdata_latched", m_rdata2, 32'hCAFEF00D);
        ddr_ready2 = 1'b0;
        m_valid2   = 2'b00;
        m_wstrb2   = '0;
        tick();

        // Stale ready: controller keeps ready high two cycles past completion
        m_addr2  = {24'h800010, 24'h000200};
        m_valid2 = 2'b01;
        tick();
        check("stale_grant_addr", ddr_addr2, 32'h000200);
        ddr_ready2 = 1'b1;
        tick();
        check("stale_mready", m_ready2, 2'b01);
        tick();
        check("stale_idle_novalid", ddr_valid2, 0);
        tick();
        check("stale_held_novalid", ddr_valid2, 0);
        ddr_ready2 = 1'b0;
        tick();
        check("stale_regrant", ddr_valid2, 1);
        ddr_ready2 = 1'b1;
        tick();
        check("stale_regrant_mready", m_ready2, 2'b01);
        ddr_ready2 = 1'b0;
        m_valid2   = 2'b00;
        tick();

        // Reset in WAIT abandons the request
        m_valid2 = 2'b10;
        tick();
        check("mid_valid", ddr_valid2, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", ddr_valid2, 0);
        check("mid_rst_ready", m_ready2, 0);
        check("mid_rst_addr", ddr_addr2, 0);
        rst = 1'b0;
        tick();
        check("mid_regrant_valid", ddr_valid2, 1);
        check("mid_regrant_addr", ddr_addr2, 32'h800010);
        check("mid_no_pulse", m_ready2, 0);
        ddr_ready2 = 1'b1;
        tick();
        check("mid_regrant_mready", m_ready2, 2'b10);
        ddr_ready2 = 1'b0;
        m_valid2   = 2'b00;
        tick();

        // Grant order with all three ports requesting continuously
        m_addr3  = {24'h000030, 24'h000020, 24'h000010};
        m_valid3 = 3'b111;
        for (int t = 0; t < 9; t++) begin
            ok = 1'b0;
            for (int c = 0; c < 10 && !ok; c++) begin
                if (ddr_valid3a && ddr_valid3f) ok = 1'b1;
                else tick();
            end
            check("fair_grant_timeout", ok, 1);
            exp_rdy = 3'b001 << (t % 3);
            check("fair_rr_addr", ddr_addr3a, 32'h10 * ((t % 3) + 1));
            check("fair_fixed_addr", ddr_addr3f, 32'h10);
            ddr_ready3 = 1'b1;
            ddr_rdata3 = 32'hA0000000 + t;
            tick();
            $display("txn %0d rr_ready=%b fixed_ready=%b", t, m_ready3a, m_ready3f);
            check("fair_rr_ready", m_ready3a, exp_rdy);
            check("fair_fixed_ready", m_ready3f, 3'b001);
            check("fair_rr_rdata", m_rdata3a, 32'hA0000000 + t);
            ddr_ready3 = 1'b0;
            tick();
        end
        m_valid3 = 3'b000;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_rr_arbiter.md
# ddr_rr_arbiter

Parametrised N-port arbiter that multiplexes several valid/ready memory masters (RISC-V core, VerilogBoy byte bridge, video fetch, …) onto the single 32-bit DDR controller port. It replaces the fixed two-master scheme with round-robin or fixed-priority arbitration. Requests and responses are fully registered, and each master gets a one-cycle ready pulse with registered read data. It sits between the masters and the DDR controller in the clkrv domain.

## Interface
- NPORTS, 2: number of masters, 2..8
- AW, 24: byte address width
- RR, 1: 1 = round-robin, 0 = fixed priority (lowest index wins)

- clkrv  in  1  system clock; all logic on its rising edge
- rst  in  1  reset; synchronous, active-high
- m_addr  in  NPORTS*AW  per-port byte address; port i at [i*AW +: AW]
- m_wdata  in  NPORTS*32  per-port write data
- m_wstrb  in  NPORTS*4  per-port byte strobes; 0 = read
- m_valid  in  NPORTS  per-port request
- m_ready  out  NPORTS  one-hot, one-cycle completion pulse
- m_rdata  out  32  read data shared by all ports; valid while m_ready[i]=1
- ddr_addr  out  AW  to controller
- ddr_wdata  out  32  to controller
- ddr_wstrb  out  4  to controller
- ddr_valid  out  1  to controller
- ddr_ready  in  1  from controller
- ddr_rdata  in  32  from controller

## Operation
- States: IDLE, WAIT, DONE.
- IDLE
  - Stay in IDLE if ddr_ready=1 (the controller has not dropped ready from the previous access), or if no m_valid bit is set.
  - Otherwise pick a winner:
    - RR=1: search starts at index last+1 and wraps modulo NPORTS.
    - RR=0: lowest set index wins.
  - Register the winner's addr/wdata/wstrb into the ddr_* outputs, set ddr_valid=1, record grant=winner and last=winner, then go to WAIT.
- WAIT
  - Hold all ddr_* outputs stable.
  - When ddr_ready=1: set ddr_valid=0, latch m_rdata<=ddr_rdata (also latched for writes), set m_ready[grant]=1, then go to DONE.
- DONE
  - m_ready[grant] stays high this cycle only; cleared on exit.
  - Go to IDLE unconditionally.
  - Masters must deassert m_valid in the cycle after they see m_ready. The arbiter never re-samples the just-served master until IDLE.
- A master's m_valid and payload must stay stable from assertion until its m_ready pulse.
  - A master that drops valid before it is granted is ignored.
  - The payload is captured at the grant edge, so later changes have no effect.
- Simultaneous requests: exactly one grant per transaction. All other requesters wait with m_ready=0.
- RR fairness: with all NPORTS requesting continuously, grants cycle 0,1,…,NPORTS-1,0… with no port skipped.
- ddr_ready high while in IDLE is treated as stale and ignored. No grant is issued until it drops.
- No address translation is done here. Masters supply their final DDR addresses (e.g. the VB bridge sets bit AW-1).

## Timing
- Reset values: ddr_valid=0, ddr_addr=0, ddr_wdata=0, ddr_wstrb=0, m_ready=0, m_rdata=0, state=IDLE, last=NPORTS-1 (so port 0 wins first in RR mode).
- rst asserted mid-transaction: next edge forces the reset values and drops ddr_valid. The in-flight request is abandoned with no m_ready pulse. The controller must tolerate valid being withdrawn.
- Latency:
  - m_valid seen at IDLE edge t → ddr_valid=1 from t+1.
  - ddr_ready sampled at edge t+k → m_ready/m_rdata valid for cycle t+k+1.
  - Earliest next grant at edge t+k+2.
- Minimum turnaround with a 1-cycle controller is 3 clkrv cycles per access.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package/header:
  - state encodings: ARB_IDLE=2'd0, ARB_WAIT=2'd1, ARB_DONE=2'd2
  - grant index width: $clog2(NPORTS), minimum 1
- One sub-module, rr_pick: combinational priority picker. Inputs are req[NPORTS], last and the RR flag; outputs are winner index and any_req. Verified standalone for all req/last combinations with NPORTS≤4.

## Test plan
- Reset: hold rst 2 cycles with m_valid=2'b11 → all outputs 0, no ddr_valid until the first edge after rst falls, then port 0 granted (RR=1).
- Single read: port 1 reads 0x800010, controller answers 0xDEADBEEF after 3 cycles → ddr_addr=0x800010 and ddr_wstrb=0. m_ready=2'b10 for exactly one cycle with m_rdata=0xDEADBEEF, 1 cycle after ddr_ready.
- Byte write: port 1 writes wstrb=4'b0100, wdata=0x00AB0000 → identical values on ddr_*. Payload stable while ddr_valid=1, even if port 1 changes m_wdata mid-WAIT.
- RR fairness: NPORTS=3, all ports request continuously for 9 transactions → grant order 0,1,2,0,1,2,0,1,2. With RR=0 the order is 0 repeated nine times.
- Stale ready: controller holds ddr_ready=1 for 2 extra cycles after completion, port 0 requesting → no new ddr_valid until the cycle after ddr_ready falls.
- Reset mid-WAIT: assert rst while ddr_valid=1 and ddr_ready=0 → ddr_valid=0 next edge, no m_ready pulse. After release, the pending port is re-granted from scratch.
